// File: rtl/nx_bit_walker.sv
// rtl/nx_bit_walker.sv - walks a bit mask, emitting set-bit indices lowest first
// Optional abort port/logic enabled by defining NX_BIT_WALKER_ABORT_EN.

module nx_clz #(
  parameter int       WIDTH         = 8,
  parameter bit       REVERSE_INPUT = 1'b0,
  parameter int       CNT_WIDTH     = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0]     i_data,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] data_v;

  always_comb begin
    data_v = i_data;
    if (REVERSE_INPUT) begin
      for (int i = 0; i < WIDTH; i++) begin
        data_v[i] = i_data[WIDTH-1-i];
      end
    end
  end

  // Ascending scan: the highest set bit of data_v wins, giving leading zeros from the MSB.
  always_comb begin
    o_count = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_v[i]) begin
        o_count = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

module nx_bit_walker #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = $clog2(WIDTH),
  parameter int CNT_WIDTH = $clog2(WIDTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [WIDTH-1:0]     i_mask,
  input  logic                 i_mask_valid,
  output logic                 o_mask_ready,
  output logic [IDX_WIDTH-1:0] o_index,
  output logic                 o_last,
  output logic                 o_empty,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_valid,
`ifdef NX_BIT_WALKER_ABORT_EN
  input  logic                 i_abort,
`endif
  input  logic                 i_ready
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     remaining_q, remaining_d;
  logic                 zero_flag_q, zero_flag_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [CNT_WIDTH-1:0] tz_count;
  logic                 tz_none;
  logic [WIDTH-1:0]     remaining_low_cleared;
  logic                 emit;
  logic                 last_beat;
  logic                 handshake;
  logic                 abort_req;

  nx_clz #(
    .WIDTH         (WIDTH),
    .REVERSE_INPUT (1'b1),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_tz (
    .i_data  (remaining_q),
    .o_count (tz_count)
  );

  assign tz_none               = (tz_count == CNT_WIDTH'(WIDTH));
  assign remaining_low_cleared = remaining_q & (remaining_q - WIDTH'(1));
  assign emit                  = (state_q == ST_EMIT);
  assign last_beat             = zero_flag_q | (remaining_low_cleared == '0);
  assign handshake             = emit & i_ready;

`ifdef NX_BIT_WALKER_ABORT_EN
  assign abort_req = emit & i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Outputs are decoded purely from registered state, so backpressure holds them stable.
  always_comb begin
    o_mask_ready = ~emit;
    o_valid      = emit;
    o_index      = '0;
    o_last       = 1'b0;
    o_empty      = 1'b0;
    o_count      = '0;
    if (emit) begin
      o_index = (zero_flag_q | tz_none) ? '0 : tz_count[IDX_WIDTH-1:0];
      o_last  = last_beat;
      o_empty = zero_flag_q;
      o_count = count_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    zero_flag_d = zero_flag_q;
    count_d     = count_q;
    case (state_q)
      ST_IDLE: begin
        if (i_mask_valid) begin
          remaining_d = i_mask;
          zero_flag_d = (i_mask == '0);
          count_d     = '0;
          state_d     = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (handshake) begin
          // Clearing the lowest set bit is the same as clearing bit o_index.
          remaining_d = remaining_low_cleared;
          count_d     = count_q + CNT_WIDTH'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
        if (abort_req) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      zero_flag_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      zero_flag_q <= zero_flag_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_nx_bit_walker.sv
// tb/tb_nx_bit_walker.sv - directed, table-driven bench for nx_bit_walker

module tb_nx_bit_walker;

  logic       clk;
  logic       rst_n;

  logic [7:0] m8;
  logic       mv8;
  logic       mr8;
  logic [2:0] idx8;
  logic       last8;
  logic       empty8;
  logic [3:0] cnt8;
  logic       val8;
  logic       rdy8;
  logic       abort8;

  logic [11:0] m12;
  logic        mv12;
  logic        mr12;
  logic [3:0]  idx12;
  logic        last12;
  logic        empty12;
  logic [4:0]  cnt12;
  logic        val12;
  logic        rdy12;
  logic        abort12;

  int checks;
  int errors;

  nx_bit_walker #(.WIDTH(8)) u_dut8 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mask       (m8),
    .i_mask_valid (mv8),
    .o_mask_ready (mr8),
    .o_index      (idx8),
    .o_last       (last8),
    .o_empty      (empty8),
    .o_count      (cnt8),
    .o_valid      (val8),
`ifdef NX_BIT_WALKER_ABORT_EN
    .i_abort      (abort8),
`endif
    .i_ready      (rdy8)
  );

  nx_bit_walker #(.WIDTH(12)) u_dut12 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mask       (m12),
    .i_mask_valid (mv12),
    .o_mask_ready (mr12),
    .o_index      (idx12),
    .o_last       (last12),
    .o_empty      (empty12),
    .o_count      (cnt12),
    .o_valid      (val12),
`ifdef NX_BIT_WALKER_ABORT_EN
    .i_abort      (abort12),
`endif
    .i_ready      (rdy12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  mask;
    int          nbeats;
    logic [31:0] idx_nibbles;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{mask: 8'hA4, nbeats: 3, idx_nibbles: 32'h0000_0752};
    vecs[1] = '{mask: 8'h00, nbeats: 1, idx_nibbles: 32'h0000_0000};
    vecs[2] = '{mask: 8'hFF, nbeats: 8, idx_nibbles: 32'h7654_3210};
    vecs[3] = '{mask: 8'h81, nbeats: 2, idx_nibbles: 32'h0000_0070};
    vecs[4] = '{mask: 8'h01, nbeats: 1, idx_nibbles: 32'h0000_0000};
    vecs[5] = '{mask: 8'h80, nbeats: 1, idx_nibbles: 32'h0000_0007};
    vecs[6] = '{mask: 8'h5A, nbeats: 4, idx_nibbles: 32'h0000_6431};

    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    m8      = '0;
    mv8     = 1'b0;
    rdy8    = 1'b1;
    abort8  = 1'b0;
    m12     = '0;
    mv12    = 1'b0;
    rdy12   = 1'b1;
    abort12 = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(val8), 32'd0);
    chk("rst_mask_ready", 32'(mr8), 32'd1);
    chk("rst_index", 32'(idx8), 32'd0);
    chk("rst_last", 32'(last8), 32'd0);
    chk("rst_empty", 32'(empty8), 32'd0);
    chk("rst_count", 32'(cnt8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      chk($sformatf("v%0d_idle_ready", v), 32'(mr8), 32'd1);
      chk($sformatf("v%0d_idle_valid", v), 32'(val8), 32'd0);
      m8  = vecs[v].mask;
      mv8 = 1'b1;
      @(negedge clk);
      mv8 = 1'b0;
      m8  = 8'hFF;
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        chk($sformatf("v%0d_b%0d_valid", v, b), 32'(val8), 32'd1);
        chk($sformatf("v%0d_b%0d_ready", v, b), 32'(mr8), 32'd0);
        chk($sformatf("v%0d_b%0d_index", v, b), 32'(idx8), (vecs[v].idx_nibbles >> (4 * b)) & 32'h7);
        chk($sformatf("v%0d_b%0d_count", v, b), 32'(cnt8), 32'(b));
        chk($sformatf("v%0d_b%0d_last", v, b), 32'(last8), 32'(b == vecs[v].nbeats - 1));
        chk($sformatf("v%0d_b%0d_empty", v, b), 32'(empty8), 32'(vecs[v].mask == 8'h00));
        @(negedge clk);
      end
    end
    chk("tbl_end_valid", 32'(val8), 32'd0);
    chk("tbl_end_ready", 32'(mr8), 32'd1);

    // Backpressure: 8'h81 held for three cycles, then both beats back to back.
    m8   = 8'h81;
    mv8  = 1'b1;
    rdy8 = 1'b0;
    @(negedge clk);
    mv8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(val8), 32'd1);
      chk($sformatf("bp%0d_index", k), 32'(idx8), 32'd0);
      chk($sformatf("bp%0d_count", k), 32'(cnt8), 32'd0);
      chk($sformatf("bp%0d_last", k), 32'(last8), 32'd0);
      @(negedge clk);
    end
    rdy8 = 1'b1;
    chk("bp_b0_index", 32'(idx8), 32'd0);
    chk("bp_b0_last", 32'(last8), 32'd0);
    @(negedge clk);
    chk("bp_b1_valid", 32'(val8), 32'd1);
    chk("bp_b1_index", 32'(idx8), 32'd7);
    chk("bp_b1_count", 32'(cnt8), 32'd1);
    chk("bp_b1_last", 32'(last8), 32'd1);
    @(negedge clk);
    chk("bp_done_valid", 32'(val8), 32'd0);
    chk("bp_done_ready", 32'(mr8), 32'd1);

    // Reset in the middle of a walk of 8'hF0.
    m8  = 8'hF0;
    mv8 = 1'b1;
    @(negedge clk);
    mv8 = 1'b0;
    chk("rw_b0_index", 32'(idx8), 32'd4);
    @(negedge clk);
    chk("rw_b1_index", 32'(idx8), 32'd5);
    chk("rw_b1_count", 32'(cnt8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_async_valid", 32'(val8), 32'd0);
    chk("rw_async_ready", 32'(mr8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rw_post_ready", 32'(mr8), 32'd1);
    m8  = 8'h02;
    mv8 = 1'b1;
    @(negedge clk);
    mv8 = 1'b0;
    chk("rw_new_valid", 32'(val8), 32'd1);
    chk("rw_new_index", 32'(idx8), 32'd1);
    chk("rw_new_count", 32'(cnt8), 32'd0);
    chk("rw_new_last", 32'(last8), 32'd1);
    @(negedge clk);
    chk("rw_new_done", 32'(val8), 32'd0);

    // Non-power-of-two width, top bit only.
    m12  = 12'h800;
    mv12 = 1'b1;
    @(negedge clk);
    mv12 = 1'b0;
    chk("w12_valid", 32'(val12), 32'd1);
    chk("w12_index", 32'(idx12), 32'd11);
    chk("w12_last", 32'(last12), 32'd1);
    chk("w12_count", 32'(cnt12), 32'd0);
    chk("w12_empty", 32'(empty12), 32'd0);
    @(negedge clk);
    chk("w12_done_valid", 32'(val12), 32'd0);
    chk("w12_done_ready", 32'(mr12), 32'd1);

`ifdef NX_BIT_WALKER_ABORT_EN
    m8  = 8'h0F;
    mv8 = 1'b1;
    @(negedge clk);
    mv8 = 1'b0;
    chk("ab_b0_index", 32'(idx8), 32'd0);
    @(negedge clk);
    chk("ab_b1_index", 32'(idx8), 32'd1);
    rdy8   = 1'b0;
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    rdy8   = 1'b1;
    chk("ab_valid", 32'(val8), 32'd0);
    chk("ab_ready", 32'(mr8), 32'd1);
    @(negedge clk);
    chk("ab_stays_idle", 32'(val8), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
